// File: rtl/prio_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arbiter_if
//  Description : Request/grant bundle between the requesters and the
//                prio_arbiter.
//                  req        : request vector, bit i = requester i
//                  done       : current grantee releases the resource
//                  gnt_valid  : a grant is held
//                  gnt_idx    : binary index of the grantee
//                  gnt_onehot : one-hot grant (0 when no grant is held)
//                modport master : requester side (drives req/done)
//                modport slave  : arbiter side (drives the grant outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
interface prio_arbiter_if #(
    parameter int N = 2
);
    logic [(1<<N)-1:0] req;
    logic              done;
    logic              gnt_valid;
    logic [N-1:0]      gnt_idx;
    logic [(1<<N)-1:0] gnt_onehot;

    modport master (
        output req,
        output done,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt_onehot
    );

    modport slave (
        input  req,
        input  done,
        output gnt_valid,
        output gnt_idx,
        output gnt_onehot
    );
endinterface
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arbiter
//  Description : Registered, locking priority arbiter for 2^N requesters.
//                Fixed mode (RR=0): highest requesting index wins.
//                Round-robin mode (RR=1): search starts at ptr and wraps;
//                ptr moves to winner+1 on every load.
//                A grant is held until the grantee asserts done; done with
//                pending requests re-arbitrates back-to-back.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - prio_arbiter_if.slave (req/done in, grant out)
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_arbiter #(
    parameter int N  = 2,
    parameter bit RR = 1'b0
) (
    input  wire              clk,
    input  wire              rst_n,
    prio_arbiter_if.slave    bus
);
    localparam int W = 1 << N;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic         r_valid;
    logic [N-1:0] r_idx;
    logic [W-1:0] r_onehot;
    logic [N-1:0] r_ptr;

    logic         w_valid_nxt;
    logic [N-1:0] w_idx_nxt;
    logic [W-1:0] w_onehot_nxt;
    logic [N-1:0] w_ptr_nxt;

    logic         w_any;
    logic         w_load;
    logic         w_clear;
    logic [N-1:0] w_win;
    logic [N-1:0] w_cand;

    assign w_any   = |bus.req;
    // In GRANT, done is the only way to move the grant (lock).
    assign w_load  = w_any && ((r_state == S_IDLE) || bus.done);
    assign w_clear = (r_state == S_GRANT) && bus.done && !w_any;

    // Winner select. Loops overwrite so the last hit is the winner:
    // ascending index for fixed priority (highest wins), descending
    // search offset for round-robin (first from ptr wins).
    always_comb begin
        w_win  = '0;
        w_cand = '0;
        if (RR == 1'b0) begin
            for (int i = 0; i < W; i++) begin
                if (bus.req[i]) begin
                    w_win = N'(i);
                end
            end
        end else begin
            for (int k = W - 1; k >= 0; k--) begin
                w_cand = r_ptr + N'(k);
                if (bus.req[w_cand]) begin
                    w_win = w_cand;
                end
            end
        end
    end

    // State register (plus the registered outputs and pointer)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_valid  <= w_valid_nxt;
            r_idx    <= w_idx_nxt;
            r_onehot <= w_onehot_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)   w_state_nxt = S_GRANT;
            S_GRANT: if (w_clear) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered grant outputs
    always_comb begin
        w_valid_nxt  = r_valid;
        w_idx_nxt    = r_idx;
        w_onehot_nxt = r_onehot;
        w_ptr_nxt    = r_ptr;
        if (w_load) begin
            w_valid_nxt  = 1'b1;
            w_idx_nxt    = w_win;
            w_onehot_nxt = W'(1) << w_win;
            if (RR == 1'b1) begin
                w_ptr_nxt = w_win + N'(1);
            end
        end else if (w_clear) begin
            w_valid_nxt  = 1'b0;
            w_idx_nxt    = '0;
            w_onehot_nxt = '0;
        end
    end

    assign bus.gnt_valid  = r_valid;
    assign bus.gnt_idx    = r_idx;
    assign bus.gnt_onehot = r_onehot;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_arbiter
//  Description : Directed bench for prio_arbiter. dut_fx runs fixed priority,
//                dut_rr runs round-robin; both share clk and rst_n.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_arbiter;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    prio_arbiter_if #(.N(2)) if_fx ();
    prio_arbiter_if #(.N(2)) if_rr ();

    prio_arbiter #(.N(2), .RR(1'b0)) dut_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fx)
    );

    prio_arbiter #(.N(2), .RR(1'b1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fx(input string tag, input logic v, input logic [1:0] idx, input logic [3:0] oh);
        check_vec({tag, ".fx.valid"},  32'(if_fx.gnt_valid),  32'(v));
        check_vec({tag, ".fx.idx"},    32'(if_fx.gnt_idx),    32'(idx));
        check_vec({tag, ".fx.onehot"}, 32'(if_fx.gnt_onehot), 32'(oh));
    endtask

    task automatic check_rr(input string tag, input logic v, input logic [1:0] idx, input logic [3:0] oh);
        check_vec({tag, ".rr.valid"},  32'(if_rr.gnt_valid),  32'(v));
        check_vec({tag, ".rr.idx"},    32'(if_rr.gnt_idx),    32'(idx));
        check_vec({tag, ".rr.onehot"}, 32'(if_rr.gnt_onehot), 32'(oh));
    endtask

    // Round-robin fairness: expected index per back-to-back grant.
    logic [1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        if_fx.req  = 4'b1111;
        if_fx.done = 1'b0;
        if_rr.req  = 4'b1111;
        if_rr.done = 1'b0;

        // Reset held with all requests asserted: no grant may appear.
        step();
        check_fx("rst0", 1'b0, 2'd0, 4'b0000);
        check_rr("rst0", 1'b0, 2'd0, 4'b0000);
        step();
        check_fx("rst1", 1'b0, 2'd0, 4'b0000);
        check_rr("rst1", 1'b0, 2'd0, 4'b0000);

        // Fixed priority: 0110 -> index 2.
        rst_n     = 1'b1;
        if_rr.req = 4'b0000;
        if_fx.req = 4'b0110;
        step();
        check_fx("fx_win", 1'b1, 2'd2, 4'b0100);
        check_rr("rr_idle", 1'b0, 2'd0, 4'b0000);

        // Lock: higher request appears, no done -> grant stays 2.
        if_fx.req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            step();
            check_fx("fx_lock", 1'b1, 2'd2, 4'b0100);
        end

        // Back-to-back release onto 0011 -> index 1.
        if_fx.done = 1'b1;
        if_fx.req  = 4'b0011;
        step();
        check_fx("fx_b2b", 1'b1, 2'd1, 4'b0010);

        // Release with no requests -> idle.
        if_fx.req = 4'b0000;
        step();
        check_fx("fx_rel", 1'b0, 2'd0, 4'b0000);

        // done in IDLE is ignored.
        step();
        check_fx("fx_idle_done", 1'b0, 2'd0, 4'b0000);
        if_fx.done = 1'b0;

        // Round-robin fairness: all requesting, done every cycle.
        if_rr.req  = 4'b1111;
        if_rr.done = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            check_rr("rr_fair", 1'b1, rr_seq[s], 4'b0001 << rr_seq[s]);
        end
        // ptr is now 1; grant index 2 so ptr becomes 3.
        if_rr.req = 4'b0100;
        step();
        check_rr("rr_to2", 1'b1, 2'd2, 4'b0100);

        // Wrap: search 3,0 -> winner 0, ptr -> 1.
        if_rr.req = 4'b0101;
        step();
        check_rr("rr_wrap", 1'b1, 2'd0, 4'b0001);
        // Search 1,2 -> winner 2.
        step();
        check_rr("rr_after_wrap", 1'b1, 2'd2, 4'b0100);

        // Get index 3, then lock it.
        if_rr.req = 4'b1000;
        step();
        check_rr("rr_to3", 1'b1, 2'd3, 4'b1000);
        if_rr.done = 1'b0;
        if_rr.req  = 4'b1111;
        step();
        check_rr("rr_lock3", 1'b1, 2'd3, 4'b1000);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_rr("arst", 1'b0, 2'd0, 4'b0000);
        check_fx("arst", 1'b0, 2'd0, 4'b0000);
        step();
        check_rr("arst_hold", 1'b0, 2'd0, 4'b0000);

        // Release reset: ptr back at 0, search 0,1 -> winner 1.
        #2;
        if_rr.req = 4'b0010;
        rst_n     = 1'b1;
        #1;
        check_rr("arst_rel", 1'b0, 2'd0, 4'b0000);
        step();
        check_rr("post_rst", 1'b1, 2'd1, 4'b0010);
        check_fx("post_rst", 1'b0, 2'd0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
